// File: rtl/lpddr2_avm_gate.sv
// Avalon-MM gate in front of the LPDDR2 MPFE port: holds traffic until the memory is ready,
// caps outstanding reads, drains on memory reset, and flushes stuck reads via a watchdog.
module lpddr2_avm_gate #(
    parameter int ADDR_W   = 27,
    parameter int MAX_PEND = 8,
    parameter int RDY_CYC  = 16,
    parameter int TMO_CYC  = 1023
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [31:0]       s_writedata,
    input  logic [3:0]        s_byteenable,
    output logic              s_waitrequest,
    output logic [31:0]       s_readdata,
    output logic              s_readdatavalid,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic [3:0]        m_byteenable,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic [3:0]        pending,
    output logic              timeout_err
);

    localparam int RW = $clog2(RDY_CYC + 1);
    localparam int WW = $clog2(TMO_CYC + 1);
    localparam logic [RW-1:0] RDY_LAST = RW'(RDY_CYC - 1);
    localparam logic [WW-1:0] TMO_LIM  = WW'(TMO_CYC);
    localparam logic [3:0]    PEND_MAX = 4'(MAX_PEND);
    localparam logic [31:0]   FLUSH_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {INIT, RUN, DRAIN, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [3:0]    pend_q, pend_d;
    logic [RW-1:0] rdy_q, rdy_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          tmo_q, tmo_d;

    logic          mrd, mwr, swait, srv, rsp, iss, block;
    logic [31:0]   srd;

    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_q <= INIT;
            pend_q  <= '0;
            rdy_q   <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        rdy_d   = '0;
        wd_d    = '0;
        tmo_d   = tmo_q;
        mrd     = 1'b0;
        mwr     = 1'b0;
        swait   = 1'b1;
        srv     = 1'b0;
        srd     = m_readdata;
        rsp     = 1'b0;
        iss     = 1'b0;
        block   = 1'b0;
        unique case (state_q)
            INIT: begin
                rdy_d = mem_ready ? rdy_q + 1'b1 : '0;
                if (mem_ready && rdy_q == RDY_LAST) begin
                    state_d = RUN;
                    rdy_d   = '0;
                end
            end
            RUN, DRAIN: begin
                rsp = m_readdatavalid && (pend_q != 4'd0);
                srv = rsp;
                if (state_q == RUN) begin
                    // A response arriving this cycle frees a slot for a read at the cap.
                    block = s_read && (pend_q == PEND_MAX) && !rsp;
                    mrd   = s_read && !block;
                    mwr   = s_write && !block;
                    swait = block || m_waitrequest;
                end
                iss = mrd && !m_waitrequest;
                if (iss && !rsp)
                    pend_d = pend_q + 4'd1;
                else if (rsp && !iss)
                    pend_d = pend_q - 4'd1;
                wd_d = (m_readdatavalid || iss || pend_q == 4'd0) ? '0 : wd_q + 1'b1;
                if (wd_q == TMO_LIM) begin
                    tmo_d   = 1'b1;
                    state_d = FLUSH;
                    wd_d    = '0;
                end else if (state_q == RUN && !mem_ready) begin
                    state_d = DRAIN;
                end else if (state_q == DRAIN && pend_d == 4'd0) begin
                    state_d = INIT;
                    wd_d    = '0;
                end
            end
            FLUSH: begin
                if (pend_q != 4'd0) begin
                    srv    = 1'b1;
                    srd    = FLUSH_WORD;
                    pend_d = pend_q - 4'd1;
                end
                if (pend_q <= 4'd1)
                    state_d = INIT;
            end
            default: state_d = INIT;
        endcase
    end

    // Command and response strobes are forced idle for as long as reset is held.
    assign s_waitrequest   = swait || avm_rst;
    assign s_readdatavalid = srv && !avm_rst;
    assign s_readdata      = srd;
    assign m_read          = mrd && !avm_rst;
    assign m_write         = mwr && !avm_rst;
    assign m_address       = s_address;
    assign m_writedata     = s_writedata;
    assign m_byteenable    = s_byteenable;
    assign pending         = pend_q;
    assign timeout_err     = tmo_q;

endmodule

// File: tb/tb_lpddr2_avm_gate.sv
// Directed bench for lpddr2_avm_gate: vector table in RUN plus startup, glitch,
// backpressure, drain, watchdog flush and mid-operation reset sequences.
module tb_lpddr2_avm_gate;

    localparam int ADDR_W = 27;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic              avm_clk = 1'b0;
    logic              avm_rst = 1'b1;
    logic              mem_ready = 1'b0;
    logic [ADDR_W-1:0] s_address = '0;
    logic              s_read = 1'b0;
    logic              s_write = 1'b0;
    logic [31:0]       s_writedata = '0;
    logic [3:0]        s_byteenable = '0;
    logic              s_waitrequest;
    logic [31:0]       s_readdata;
    logic              s_readdatavalid;
    logic [ADDR_W-1:0] m_address;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_waitrequest = 1'b0;
    logic [31:0]       m_readdata = '0;
    logic              m_readdatavalid = 1'b0;
    logic [3:0]        pending;
    logic              timeout_err;

    lpddr2_avm_gate #(.ADDR_W(ADDR_W), .MAX_PEND(8), .RDY_CYC(16), .TMO_CYC(1023)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst), .mem_ready(mem_ready),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .s_readdatavalid(s_readdatavalid), .m_address(m_address),
        .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .pending(pending), .timeout_err(timeout_err)
    );

    always #5 avm_clk = ~avm_clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        rd, wr, mw, rv;
        logic [31:0] rdata;
        logic        e_mrd, e_mwr, e_swt, e_srv;
        logic [3:0]  e_pend;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge avm_clk);
        #1;
    endtask

    task automatic wait_run(output int first);
        first = -1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (m_read === 1'b1) begin
                first = c;
                break;
            end
            tick();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench stalled");
    end

    initial begin
        int first;
        int v_first, v_cnt, v_bad;
        logic te_1023;
        logic [3:0] pat;

        //                 rd wr mw rv rdata          mrd mwr swt srv pend
        tbl[0] = '{H, L, L, L, 32'h0000_0000, H, L, L, L, 4'd1};
        tbl[1] = '{H, L, H, L, 32'h0000_0000, H, L, H, L, 4'd1};
        tbl[2] = '{L, H, L, L, 32'h0000_0000, L, H, L, L, 4'd1};
        tbl[3] = '{L, L, L, H, 32'h1234_5678, L, L, L, H, 4'd0};
        tbl[4] = '{L, L, L, H, 32'h0BAD_0BAD, L, L, L, L, 4'd0};
        tbl[5] = '{H, H, L, L, 32'h0000_0000, H, H, L, L, 4'd1};
        tbl[6] = '{H, L, L, H, 32'hCAFE_F00D, H, L, L, H, 4'd1};
        tbl[7] = '{L, H, H, L, 32'h0000_0000, L, H, H, L, 4'd1};
        tbl[8] = '{L, L, L, H, 32'h5555_AAAA, L, L, L, H, 4'd0};
        tbl[9] = '{H, L, H, H, 32'h0000_0077, H, L, H, L, 4'd0};

        // Reset hold with aggressive inputs
        avm_rst = 1'b1; mem_ready = 1'b1; s_read = 1'b1; m_waitrequest = 1'b1;
        m_readdatavalid = 1'b1;
        repeat (3) tick();
        #1;
        chk("rst_swait", 32'(s_waitrequest), 32'd1);
        chk("rst_mread", 32'(m_read), 32'd0);
        chk("rst_srdv", 32'(s_readdatavalid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        tick();

        // Startup: mem_ready high from cycle 0, first m_read on cycle 16
        avm_rst = 1'b0; m_readdatavalid = 1'b0;
        wait_run(first);
        chk("startup_first_mread", 32'(first), 32'd16);
        chk("startup_swait_mwait", 32'(s_waitrequest), 32'd1);
        tick();
        s_read = 1'b0; m_waitrequest = 1'b0;

        // Table-driven vectors in RUN
        for (int i = 0; i < 10; i++) begin
            s_read = tbl[i].rd; s_write = tbl[i].wr;
            m_waitrequest = tbl[i].mw; m_readdatavalid = tbl[i].rv;
            m_readdata = tbl[i].rdata;
            s_address = ADDR_W'(32'h0100_0000 + i);
            s_writedata = 32'hA000_0000 + 32'(i);
            s_byteenable = 4'(i + 1);
            #1;
            chk($sformatf("v%0d_mread", i), 32'(m_read), 32'(tbl[i].e_mrd));
            chk($sformatf("v%0d_mwrite", i), 32'(m_write), 32'(tbl[i].e_mwr));
            chk($sformatf("v%0d_swait", i), 32'(s_waitrequest), 32'(tbl[i].e_swt));
            chk($sformatf("v%0d_srdv", i), 32'(s_readdatavalid), 32'(tbl[i].e_srv));
            if (tbl[i].e_srv) chk($sformatf("v%0d_srdata", i), s_readdata, tbl[i].rdata);
            chk($sformatf("v%0d_maddr", i), 32'(m_address), 32'h0100_0000 + 32'(i));
            chk($sformatf("v%0d_mwdata", i), m_writedata, 32'hA000_0000 + 32'(i));
            chk($sformatf("v%0d_mbe", i), 32'(m_byteenable), 32'(i + 1));
            tick();
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(tbl[i].e_pend));
        end
        s_read = 1'b0; s_write = 1'b0; m_waitrequest = 1'b0; m_readdatavalid = 1'b0;

        // Glitch: back to INIT, then 10 high, 1 low, high again
        mem_ready = 1'b0;
        repeat (3) tick();
        s_read = 1'b1; m_waitrequest = 1'b1;
        first = -1;
        for (int c = 0; c < 60; c++) begin
            mem_ready = (c != 10);
            #1;
            if (m_read === 1'b1) begin
                first = c;
                break;
            end
            tick();
        end
        chk("glitch_first_mread", 32'(first), 32'd27);
        tick();
        s_read = 1'b0; m_waitrequest = 1'b0;

        // Backpressure at 8 outstanding
        s_read = 1'b1;
        repeat (8) tick();
        chk("bp_pending8", 32'(pending), 32'd8);
        #1;
        chk("bp_9th_swait", 32'(s_waitrequest), 32'd1);
        chk("bp_9th_mread", 32'(m_read), 32'd0);
        tick();
        chk("bp_still8", 32'(pending), 32'd8);
        m_readdatavalid = 1'b1; m_readdata = 32'h1111_2222;
        #1;
        chk("bp_rsp_mread", 32'(m_read), 32'd1);
        chk("bp_rsp_swait", 32'(s_waitrequest), 32'd0);
        chk("bp_rsp_srdv", 32'(s_readdatavalid), 32'd1);
        chk("bp_rsp_srdata", s_readdata, 32'h1111_2222);
        tick();
        s_read = 1'b0;
        chk("bp_after_pending", 32'(pending), 32'd8);

        // Drain: reduce to 3, drop mem_ready, responses 1,0,1,1
        repeat (5) tick();
        m_readdatavalid = 1'b0;
        chk("drain_pending3", 32'(pending), 32'd3);
        mem_ready = 1'b0;
        tick();
        s_read = 1'b1; s_write = 1'b1;
        #1;
        chk("drain_mread", 32'(m_read), 32'd0);
        chk("drain_mwrite", 32'(m_write), 32'd0);
        chk("drain_swait", 32'(s_waitrequest), 32'd1);
        pat = 4'b1101;
        for (int j = 0; j < 4; j++) begin
            m_readdatavalid = pat[j];
            m_readdata = 32'hD000_0000 + 32'(j);
            #1;
            chk($sformatf("drain_srdv%0d", j), 32'(s_readdatavalid), 32'(pat[j]));
            chk($sformatf("drain_cmd%0d", j), 32'({m_read, m_write}), 32'd0);
            tick();
        end
        chk("drain_end_pending", 32'(pending), 32'd0);
        m_readdatavalid = 1'b1;
        #1;
        chk("init_drop_rdv", 32'(s_readdatavalid), 32'd0);
        chk("init_swait", 32'(s_waitrequest), 32'd1);
        tick();
        chk("init_pending0", 32'(pending), 32'd0);
        m_readdatavalid = 1'b0; s_read = 1'b0; s_write = 1'b0;
        tick();

        // Watchdog: 2 reads outstanding, no responses
        mem_ready = 1'b1; s_read = 1'b1; m_waitrequest = 1'b1;
        wait_run(first);
        chk("tmo_run_first", 32'(first), 32'd16);
        m_waitrequest = 1'b0;
        tick();
        tick();
        s_read = 1'b0;
        chk("tmo_pending2", 32'(pending), 32'd2);
        v_first = -1; v_cnt = 0; v_bad = 0; te_1023 = 1'b1;
        for (int k = 0; k < 1030; k++) begin
            #1;
            if (k == 1023) te_1023 = timeout_err;
            if (s_readdatavalid === 1'b1) begin
                if (v_first < 0) v_first = k;
                v_cnt++;
                if (s_readdata !== 32'hDEADBEEF || k > v_first + 1) v_bad++;
            end
            tick();
        end
        chk("tmo_flag_before", 32'(te_1023), 32'd0);
        chk("tmo_first_flush", 32'(v_first), 32'd1024);
        chk("tmo_flush_count", 32'(v_cnt), 32'd2);
        chk("tmo_flush_data", 32'(v_bad), 32'd0);
        chk("tmo_flag", 32'(timeout_err), 32'd1);
        chk("tmo_pending0", 32'(pending), 32'd0);
        m_readdatavalid = 1'b1;
        #1;
        chk("tmo_init_drop", 32'(s_readdatavalid), 32'd0);
        tick();
        m_readdatavalid = 1'b0;

        // Reset mid-operation with reads outstanding
        s_read = 1'b1; m_waitrequest = 1'b1;
        wait_run(first);
        chk("mrst_reached_run", 32'(first >= 0), 32'd1);
        m_waitrequest = 1'b0;
        tick();
        tick();
        s_read = 1'b0;
        chk("mrst_pending2", 32'(pending), 32'd2);
        chk("mrst_tmo_sticky", 32'(timeout_err), 32'd1);
        avm_rst = 1'b1; m_readdatavalid = 1'b1; s_read = 1'b1;
        #1;
        chk("mrst_swait", 32'(s_waitrequest), 32'd1);
        chk("mrst_srdv", 32'(s_readdatavalid), 32'd0);
        chk("mrst_mread", 32'(m_read), 32'd0);
        tick();
        chk("mrst_pending0", 32'(pending), 32'd0);
        chk("mrst_tmo_clear", 32'(timeout_err), 32'd0);
        tick();
        avm_rst = 1'b0;
        #1;
        chk("mrst_no_resp", 32'(s_readdatavalid), 32'd0);
        tick();
        m_readdatavalid = 1'b0; s_read = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
